// File: rtl/ysyx_24110015_pkg.sv
// Shared definitions for the multiply/divide unit: RV M-extension func3
// encodings, FSM state encoding, the latched-op record and signedness helpers.
package ysyx_24110015_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // Op captured at accept; sign_* are the effective operand signs.
    typedef struct packed {
        logic [2:0] func3;
        logic       sign_a;
        logic       sign_b;
    } mdu_op_t;

    // rs1 is signed for mul/mulh/mulhsu and div/rem.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3 != F3_MULHU);
    endfunction

    // rs2 is signed for mul/mulh and div/rem.
    function automatic logic b_is_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : ~f3[1];
    endfunction

endpackage

// File: rtl/ysyx_24110015_mdu_div.sv
// Iterative radix-2 restoring divider on unsigned magnitudes. One quotient
// bit per cycle; done is high during the last iteration, with quotient and
// remainder presenting that final step combinationally.
module ysyx_24110015_mdu_div
    import ysyx_24110015_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN) + 1;

    logic            run_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dsr_q;
    logic [XLEN:0]   shifted, diff;
    logic            ge;
    logic [XLEN-1:0] step_quo, step_rem;

    // Shift in the next dividend bit and trial-subtract the divisor.
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dsr_q};
    assign ge       = ~diff[XLEN];
    assign step_rem = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign step_quo = {quo_q[XLEN-2:0], ge};

    assign done      = run_q && (cnt_q == CW'(XLEN - 1));
    assign quotient  = step_quo;
    assign remainder = step_rem;

    // Load operands on start, then retire one quotient bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (flush) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (run_q) begin
            quo_q <= step_quo;
            rem_q <= step_rem;
            cnt_q <= cnt_q + 1'b1;
            if (done) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_24110015_mdu.sv
// RV M-extension multiply/divide unit. Valid/ready in, valid/ready out.
// Iterative ops spend XLEN cycles in CALC; divide-by-zero, signed overflow
// and (with FAST_MUL) multiplies complete one cycle after accept.
module ysyx_24110015_mdu
    import ysyx_24110015_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_o,
    input  logic            flush,
    output logic            busy
);
    localparam int              CW      = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    mdu_op_t         op_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;

    logic            accept, in_div, in_sa, in_sb, in_dz, in_ovf, in_fast, last;
    logic [XLEN-1:0] in_ma, in_mb, fast_res, fmul_res, mul_res, div_res;
    logic            div_done;
    logic [XLEN-1:0] div_q, div_r;

    assign in_ready  = (state_q == MDU_IDLE);
    assign out_valid = (state_q == MDU_DONE);
    assign busy      = (state_q != MDU_IDLE);
    assign result    = result_q;
    assign rd_o      = rd_q;

    // Flush wins over a same-cycle request.
    assign accept  = in_valid & in_ready & ~flush;

    // Request-side decode, evaluated on the raw inputs at accept time.
    assign in_div  = func3[2];
    assign in_sa   = a_is_signed(func3) & op_a[XLEN-1];
    assign in_sb   = b_is_signed(func3) & op_b[XLEN-1];
    assign in_ma   = in_sa ? -op_a : op_a;
    assign in_mb   = in_sb ? -op_b : op_b;
    assign in_dz   = in_div & (op_b == '0);
    assign in_ovf  = in_div & ~func3[0] & (op_a == MIN_VAL) & (op_b == '1);
    assign in_fast = in_dz | in_ovf | (~in_div & (FAST_MUL != 0));

    // Result for ops that skip CALC.
    always_comb begin
        fast_res = fmul_res;
        if (in_dz)       fast_res = func3[1] ? op_a : '1;
        else if (in_ovf) fast_res = func3[1] ? '0   : MIN_VAL;
    end

    generate
        if (FAST_MUL != 0) begin : g_fast_mul
            logic [2*XLEN-1:0] ext_a, ext_b, prod;
            // Sign/zero-extended operands: the low 2*XLEN product bits are exact.
            assign ext_a    = {{XLEN{in_sa}}, op_a};
            assign ext_b    = {{XLEN{in_sb}}, op_b};
            assign prod     = ext_a * ext_b;
            assign fmul_res = (func3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            assign mul_res  = '0;
        end else begin : g_iter_mul
            logic [XLEN-1:0]   ma_q;
            logic [2*XLEN-1:0] prod_q, prod_nxt, prod_signed;
            logic [XLEN:0]     sum;
            // Radix-2 shift-add: multiplier sits in the low half and is consumed LSB first.
            assign sum         = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, ma_q} : '0);
            assign prod_nxt    = {sum, prod_q[XLEN-1:1]};
            assign prod_signed = (op_q.sign_a ^ op_q.sign_b) ? -prod_nxt : prod_nxt;
            assign mul_res     = (op_q.func3 == F3_MUL) ? prod_signed[XLEN-1:0]
                                                        : prod_signed[2*XLEN-1:XLEN];
            assign fmul_res    = '0;

            // Load magnitudes on accept, then one partial-product step per CALC cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ma_q   <= '0;
                    prod_q <= '0;
                end else if (accept) begin
                    ma_q   <= in_ma;
                    prod_q <= {{XLEN{1'b0}}, in_mb};
                end else if (state_q == MDU_CALC && !op_q.func3[2]) begin
                    prod_q <= prod_nxt;
                end
            end
        end
    endgenerate

    ysyx_24110015_mdu_div #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept & in_div & ~in_fast),
        .flush     (flush),
        .dividend  (in_ma),
        .divisor   (in_mb),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Quotient takes sign(a)^sign(b); remainder follows the dividend.
    assign div_res = op_q.func3[1] ? (op_q.sign_a ? -div_r : div_r)
                                   : ((op_q.sign_a ^ op_q.sign_b) ? -div_q : div_q);

    assign last = (state_q == MDU_CALC) &&
                  (op_q.func3[2] ? div_done : (cnt_q == CW'(XLEN - 1)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MDU_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (accept)    state_d = in_fast ? MDU_DONE : MDU_CALC;
            MDU_CALC: if (last)      state_d = MDU_DONE;
            MDU_DONE: if (out_ready) state_d = MDU_IDLE;
            default:                 state_d = MDU_IDLE;
        endcase
        if (flush) state_d = MDU_IDLE;
    end

    // Capture the request, count CALC cycles, and register the final result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else if (flush) begin
            cnt_q    <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            op_q     <= '{func3: func3, sign_a: in_sa, sign_b: in_sb};
            rd_q     <= rd_i;
            if (in_fast) result_q <= fast_res;
        end else if (state_q == MDU_CALC) begin
            cnt_q    <= cnt_q + 1'b1;
            if (last) result_q <= op_q.func3[2] ? div_res : mul_res;
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_mdu.sv
// Scoreboard bench for the MDU: the driver pushes hand-computed results,
// the monitor pops and compares on every out_valid&out_ready.
module tb_ysyx_24110015_mdu;
    import ysyx_24110015_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, flush, busy;
    logic [2:0]  func3;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  rd_i, rd_o;

    ysyx_24110015_mdu #(.XLEN(32), .FAST_MUL(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func3     (func3),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_i      (rd_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_o      (rd_o),
        .flush     (flush),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Drive point: 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat,
                         input bit track);
        int n = 0;
        exp_t e;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            fail_now("issue_wait_ready");
            return;
        end
        in_valid = 1'b1;
        func3 = f; op_a = a; op_b = b; rd_i = rd;
        if (track) begin
            e.res = exp; e.rd = rd; e.acc = cyc; e.lat = lat;
            sb.push_back(e);
        end
        step();
        // Scramble inputs: the unit must use only what it latched.
        in_valid = 1'b0;
        func3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_i = 5'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            step();
            n++;
        end
        if (sb.size() != 0) fail_now("drain_scoreboard");
    endtask

    task automatic quiet(input string name, input int ncyc);
        int seen = 0;
        repeat (ncyc) begin
            step();
            if (out_valid) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        exp_t e;
        bit   prev_v;
        int   rise;
        prev_v = 1'b0;
        rise   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) rise = cyc;
                prev_v = out_valid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: result 0x%08h rd %0d, none expected", result, rd_o);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("result_rd%0d", e.rd), result, e.res);
                        chk($sformatf("rd_o_rd%0d", e.rd), 32'(rd_o), 32'(e.rd));
                        chk($sformatf("latency_rd%0d", e.rd), 32'(rise - e.acc), 32'(e.lat));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        func3 = '0; op_a = '0; op_b = '0; rd_i = '0;
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_result",    result,         32'd0);
        chk("rst_rd_o",      32'(rd_o),      32'd0);
        rst = 1'b0;
        step();
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Multiplies (iterative: 33 cycles accept-to-valid)
        issue(F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33, 1'b1);
        issue(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33, 1'b1);
        issue(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000, 33, 1'b1);
        issue(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 33, 1'b1);
        issue(F3_MUL,    32'h12345678, 32'h00000010, 5'd5, 32'h23456780, 33, 1'b1);
        issue(F3_MULHU,  32'h80000000, 32'h00000004, 5'd6, 32'h00000002, 33, 1'b1);
        // Divides, including sign handling
        issue(F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33, 1'b1);
        issue(F3_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33, 1'b1);
        issue(F3_DIVU,   32'd100,      32'd7,        5'd14, 32'd14,       33, 1'b1);
        issue(F3_REMU,   32'd100,      32'd7,        5'd15, 32'd2,        33, 1'b1);
        issue(F3_DIV,    32'd7,        32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 33, 1'b1);
        issue(F3_REM,    32'd7,        32'hFFFFFFFE, 5'd17, 32'd1,        33, 1'b1);
        issue(F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        33, 1'b1);
        // Divide by zero and signed overflow take the one-cycle path
        issue(F3_DIVU,   32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1, 1'b1);
        issue(F3_REMU,   32'd5,        32'd0,        5'd10, 32'd5,        1, 1'b1);
        issue(F3_REM,    32'hFFFFFFF9, 32'd0,        5'd11, 32'hFFFFFFF9, 1, 1'b1);
        issue(F3_DIV,    32'hFFFFFFFF, 32'd0,        5'd19, 32'hFFFFFFFF, 1, 1'b1);
        issue(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1, 1'b1);
        issue(F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1, 1'b1);
        drain();

        // Back-pressure: DONE holds for 10 cycles with stable outputs
        out_ready = 1'b0;
        issue(F3_MUL, 32'd3, 32'd5, 5'd20, 32'd15, 33, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                step();
                n++;
            end
            if (!out_valid) fail_now("stall_wait_valid");
        end
        repeat (10) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_result",    result,         32'd15);
            chk("stall_rd_o",      32'(rd_o),      32'd20);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_busy",      32'(busy),      32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready",  32'(in_ready),  32'd1);
        drain();

        // Flush in CALC cycle 5 with a competing request
        issue(F3_DIV, 32'd1000, 32'd3, 5'd21, 32'd0, 0, 1'b0);
        repeat (4) step();
        chk("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1; in_valid = 1'b1;
        func3 = F3_MUL; op_a = 32'd2; op_b = 32'd3; rd_i = 5'd22;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy_after",  32'(busy),      32'd0);
        chk("flush_in_ready",    32'(in_ready),  32'd1);
        chk("flush_out_valid",   32'(out_valid), 32'd0);
        quiet("flush_no_out_valid", 40);

        // Reset in the middle of CALC
        issue(F3_MUL, 32'd9, 32'd9, 5'd23, 32'd0, 0, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_result",    result,         32'd0);
        chk("midrst_rd_o",      32'(rd_o),      32'd0);
        rst = 1'b0;
        step();
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        quiet("midrst_no_out_valid", 40);

        // Recovery after reset
        issue(F3_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd24, 32'd1, 33, 1'b1);
        drain();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
